mvm_stream: RTL

MVM_STREAM -- requirements
Module: mvm_stream

---
 rtl/mvm_stream_if.sv | 48 ++++
 rtl/mvm_stream.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mvm_stream_if.sv
// mvm_stream_if: memory-write, command and result handshake bundle.
// master is the host side, slave is the mvm_stream engine.
interface mvm_stream_if #(
    parameter int IWIDTH     = 8,
    parameter int OWIDTH     = 32,
    parameter int LANES      = 8,
    parameter int NUM_OLANES = 8,
    parameter int VEC_DEPTH  = 256,
    parameter int MAT_DEPTH  = 512
);
    localparam int MEM_DATAW = IWIDTH * LANES;
    localparam int VEC_ADDRW = $clog2(VEC_DEPTH);
    localparam int MAT_ADDRW = $clog2(MAT_DEPTH);

    logic [MEM_DATAW-1:0]         i_vec_wdata;
    logic [VEC_ADDRW-1:0]         i_vec_waddr;
    logic                         i_vec_wen;
    logic [MEM_DATAW-1:0]         i_mat_wdata;
    logic [MAT_ADDRW-1:0]         i_mat_waddr;
    logic [NUM_OLANES-1:0]        i_mat_wen;
    logic                         i_start;
    logic [VEC_ADDRW-1:0]         i_vec_start_addr;
    logic [VEC_ADDRW:0]           i_vec_num_words;
    logic [MAT_ADDRW-1:0]         i_mat_start_addr;
    logic [MAT_ADDRW:0]           i_mat_num_rows;
    logic                         o_cmd_ready;
    logic                         o_busy;
    logic [OWIDTH*NUM_OLANES-1:0] o_result;
    logic                         o_valid;
    logic                         i_ready;
    logic                         o_last;

    modport master (
        output i_vec_wdata, i_vec_waddr, i_vec_wen,
        output i_mat_wdata, i_mat_waddr, i_mat_wen,
        output i_start, i_vec_start_addr, i_vec_num_words,
        output i_mat_start_addr, i_mat_num_rows, i_ready,
        input  o_cmd_ready, o_busy, o_result, o_valid, o_last
    );

    modport slave (
        input  i_vec_wdata, i_vec_waddr, i_vec_wen,
        input  i_mat_wdata, i_mat_waddr, i_mat_wen,
        input  i_start, i_vec_start_addr, i_vec_num_words,
        input  i_mat_start_addr, i_mat_num_rows, i_ready,
        output o_cmd_ready, o_busy, o_result, o_valid, o_last
    );
endinterface

// File: rtl/mvm_stream.sv
// mvm_stream: streaming signed matrix-vector multiply, NUM_OLANES rows per pass.
// Define MVM_STREAM_RELU_EN to clamp negative row results to zero.
module mvm_stream #(
    parameter int IWIDTH      = 8,
    parameter int OWIDTH      = 32,
    parameter int LANES       = 8,
    parameter int NUM_OLANES  = 8,
    parameter int VEC_DEPTH   = 256,
    parameter int MAT_DEPTH   = 512,
    parameter int OFIFO_DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    mvm_stream_if.slave bus
);
    localparam int MEM_DATAW = IWIDTH * LANES;
    localparam int VAW = $clog2(VEC_DEPTH);
    localparam int MAW = $clog2(MAT_DEPTH);
    localparam int TL  = $clog2(LANES);
    localparam int PD  = 2 + TL;
    localparam int NN  = 2 * LANES - 1;
    localparam int FAW = $clog2(OFIFO_DEPTH);
    localparam int FCW = FAW + 1;
    localparam int RW  = NUM_OLANES * OWIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [VAW-1:0]       vstart_q, vstart_d, vaddr_q, vaddr_d;
    logic [VAW:0]         nw_q, nw_d, w_q, w_d;
    logic [MAW:0]         rows_q, rows_d, r_q, r_d;
    logic [MAW-1:0]       maddr_q, maddr_d;
    logic [FCW-1:0]       infl_q, infl_d, cnt_q, cnt_d;
    logic [FAW-1:0]       wp_q, wp_d, rp_q, rp_d;
    logic [PD-1:0]        vld_q, vld_d, fst_q, fst_d;
    logic [PD-1:0]        lst_q, lst_d, cls_q, cls_d;
    logic signed [OWIDTH-1:0] node_q [NUM_OLANES][NN];
    logic signed [OWIDTH-1:0] node_d [NUM_OLANES][NN];
    logic signed [OWIDTH-1:0] acc_q [NUM_OLANES];
    logic signed [OWIDTH-1:0] acc_d [NUM_OLANES];
    logic [RW:0]          fifo_q [OFIFO_DEPTH];
    logic [RW:0]          fifo_d [OFIFO_DEPTH];
    logic [RW:0]          wr_ent;
    logic signed [OWIDTH-1:0] op_a, op_b, res;
    logic                 issue, push, pop, valid, w_last, r_last;

    logic [MEM_DATAW-1:0] vec_mem [VEC_DEPTH];
    logic [MEM_DATAW-1:0] mat_mem [NUM_OLANES][MAT_DEPTH];
    logic [MEM_DATAW-1:0] vec_rd_q;
    logic [MEM_DATAW-1:0] mat_rd_q [NUM_OLANES];

    // Non-blocking read beside the write gives old data on collision
    always_ff @(posedge clk) begin
        if (bus.i_vec_wen) vec_mem[bus.i_vec_waddr] <= bus.i_vec_wdata;
        vec_rd_q <= vec_mem[vaddr_q];
        for (int o = 0; o < NUM_OLANES; o++) begin
            if (bus.i_mat_wen[o]) mat_mem[o][bus.i_mat_waddr] <= bus.i_mat_wdata;
            mat_rd_q[o] <= mat_mem[o][maddr_q];
        end
    end

    assign valid  = cnt_q != '0;
    assign pop    = valid && bus.i_ready;
    assign w_last = w_q == nw_q - 1'b1;
    assign r_last = r_q == rows_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        vstart_d = vstart_q;
        vaddr_d  = vaddr_q;
        nw_d     = nw_q;
        w_d      = w_q;
        rows_d   = rows_q;
        r_d      = r_q;
        maddr_d  = maddr_q;
        issue    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    vstart_d = bus.i_vec_start_addr;
                    vaddr_d  = bus.i_vec_start_addr;
                    nw_d     = bus.i_vec_num_words;
                    rows_d   = bus.i_mat_num_rows;
                    maddr_d  = bus.i_mat_start_addr;
                    w_d      = '0;
                    r_d      = '0;
                    if (bus.i_vec_num_words != '0 && bus.i_mat_num_rows != '0)
                        state_d = RUN;
                end
            end
            RUN: begin
                // A row only starts once a FIFO slot is reserved for it
                issue = (w_q != '0) || (cnt_q + infl_q < FCW'(OFIFO_DEPTH));
                if (issue) begin
                    maddr_d = (maddr_q == MAW'(MAT_DEPTH - 1)) ? '0 : maddr_q + 1'b1;
                    if (w_last) begin
                        w_d     = '0;
                        r_d     = r_q + 1'b1;
                        vaddr_d = vstart_q;
                        if (r_last) state_d = DRAIN;
                    end else begin
                        w_d     = w_q + 1'b1;
                        vaddr_d = (vaddr_q == VAW'(VEC_DEPTH - 1)) ? '0 : vaddr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (infl_q == '0 && (cnt_q == '0 || (cnt_q == FCW'(1) && pop)))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_d  = {vld_q[PD-2:0], issue};
        fst_d  = {fst_q[PD-2:0], issue && w_q == '0};
        lst_d  = {lst_q[PD-2:0], issue && w_last};
        cls_d  = {cls_q[PD-2:0], issue && w_last && r_last};
        push   = vld_q[PD-1] && lst_q[PD-1];
        wr_ent = '0;
        wr_ent[RW] = cls_q[PD-1];
        op_a   = '0;
        op_b   = '0;
        res    = '0;
        for (int o = 0; o < NUM_OLANES; o++) begin
            // Heap-ordered tree: node i sums children 2i+1 and 2i+2
            for (int i = 0; i < LANES - 1; i++)
                node_d[o][i] = node_q[o][2*i+1] + node_q[o][2*i+2];
            for (int i = 0; i < LANES; i++) begin
                op_a = OWIDTH'($signed(vec_rd_q[i*IWIDTH +: IWIDTH]));
                op_b = OWIDTH'($signed(mat_rd_q[o][i*IWIDTH +: IWIDTH]));
                node_d[o][LANES-1+i] = op_a * op_b;
            end
            acc_d[o] = acc_q[o];
            if (vld_q[PD-1])
                acc_d[o] = (fst_q[PD-1] ? '0 : acc_q[o]) + node_q[o][0];
`ifdef MVM_STREAM_RELU_EN
            res = acc_d[o][OWIDTH-1] ? '0 : acc_d[o];
`else
            res = acc_d[o];
`endif
            wr_ent[o*OWIDTH +: OWIDTH] = res;
        end
        fifo_d = fifo_q;
        if (push) fifo_d[wp_q] = wr_ent;
        wp_d   = push ? wp_q + 1'b1 : wp_q;
        rp_d   = pop ? rp_q + 1'b1 : rp_q;
        cnt_d  = cnt_q + FCW'(push) - FCW'(pop);
        infl_d = infl_q + FCW'(issue && w_q == '0) - FCW'(push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vstart_q <= '0;
            vaddr_q  <= '0;
            nw_q     <= '0;
            w_q      <= '0;
            rows_q   <= '0;
            r_q      <= '0;
            maddr_q  <= '0;
            infl_q   <= '0;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            vld_q    <= '0;
            fst_q    <= '0;
            lst_q    <= '0;
            cls_q    <= '0;
            for (int o = 0; o < NUM_OLANES; o++) acc_q[o] <= '0;
        end else begin
            state_q  <= state_d;
            vstart_q <= vstart_d;
            vaddr_q  <= vaddr_d;
            nw_q     <= nw_d;
            w_q      <= w_d;
            rows_q   <= rows_d;
            r_q      <= r_d;
            maddr_q  <= maddr_d;
            infl_q   <= infl_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            vld_q    <= vld_d;
            fst_q    <= fst_d;
            lst_q    <= lst_d;
            cls_q    <= cls_d;
            for (int o = 0; o < NUM_OLANES; o++) acc_q[o] <= acc_d[o];
        end
    end

    always_ff @(posedge clk) begin
        node_q <= node_d;
        fifo_q <= fifo_d;
    end

    assign bus.o_valid     = valid;
    assign bus.o_result    = valid ? fifo_q[rp_q][RW-1:0] : '0;
    assign bus.o_last      = valid && fifo_q[rp_q][RW];
    assign bus.o_busy      = state_q != IDLE;
    assign bus.o_cmd_ready = state_q == IDLE;
endmodule
